// File: rtl/ling_add64_seq.sv
// rtl/ling_add64_seq.sv - 64-bit add sequenced over one external 32-bit sum-only Ling adder
module ling_add64_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_a,
  input  logic [2*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_sum,
  output logic           out_cout,
  output logic           busy,
  output logic [W-1:0]   adder_a,
  output logic [W-1:0]   adder_b,
  input  logic [W-1:0]   adder_sum
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_INC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [2:0]     state_q, state_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic [2*W-1:0] s_q, s_d;
  logic           c_lo_q, c_lo_d;
  logic           c_hi_q, c_hi_d;
  logic           pass_carry;

  // The adder has no carry-out, so recover it from the operand and sum MSBs.
  assign pass_carry = (adder_a[W-1] & adder_b[W-1]) |
                      ((adder_a[W-1] ^ adder_b[W-1]) & ~adder_sum[W-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_lo_d  = c_lo_q;
    c_hi_d  = c_hi_q;
    adder_a = '0;
    adder_b = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_LO;
        end
      end
      S_LO: begin
        adder_a       = a_q[W-1:0];
        adder_b       = b_q[W-1:0];
        s_d[W-1:0]    = adder_sum;
        c_lo_d        = pass_carry;
        state_d       = S_HI;
      end
      S_HI: begin
        adder_a       = a_q[2*W-1:W];
        adder_b       = b_q[2*W-1:W];
        s_d[2*W-1:W]  = adder_sum;
        c_hi_d        = pass_carry;
        state_d       = c_lo_q ? S_INC : S_DONE;
      end
      S_INC: begin
        // Only an all-ones high word can carry out of the +1.
        adder_a       = s_q[2*W-1:W];
        adder_b       = ONE;
        s_d[2*W-1:W]  = adder_sum;
        c_hi_d        = c_hi_q | (s_q[2*W-1:W] == {W{1'b1}});
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_lo_q  <= 1'b0;
      c_hi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_lo_q  <= c_lo_d;
      c_hi_q  <= c_hi_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = s_q;
  assign out_cout  = c_hi_q;

endmodule

// File: tb/tb_ling_add64_seq.sv
// tb/tb_ling_add64_seq.sv - directed-vector bench for ling_add64_seq
module tb_ling_add64_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        busy;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic [31:0] adder_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the 32-bit sum-only Ling adder.
  assign adder_sum = adder_a + adder_b;

  ling_add64_seq #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy), .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency counts cycles from the accepting cycle to the first out_valid cycle.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_s, input logic exp_c,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_sum"}, out_sum, exp_s);
    check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp_c});
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      in_a     = ~a;
      in_b     = ~b;
      @(negedge clk);
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_sum"}, out_sum, exp_s);
      check({tag, "_hold_cout"}, {63'd0, out_cout}, {63'd0, exp_c});
      check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_drain_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_adder_a", {32'd0, adder_a}, 64'd0);

    run_op("c1", 64'h00000001_00000002, 64'h00000002_00000003, 64'h00000003_00000005, 1'b0, 3, 0);
    run_op("c2", 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 64'h00000001_00000000, 1'b0, 4, 0);
    run_op("c3", 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 64'h00000000_00000000, 1'b1, 4, 0);
    run_op("c4", 64'h80000000_80000000, 64'h80000000_80000000, 64'h00000001_00000000, 1'b1, 4, 0);
    run_op("mix", 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 64'h23456789_ABCDF001, 1'b0, 3, 0);
    run_op("hicy", 64'hFFFFFFFF_00000000, 64'h00000001_00000000, 64'h00000000_00000000, 1'b1, 3, 0);

    run_op("bp", 64'h00000001_00000002, 64'h00000002_00000003, 64'h00000003_00000005, 1'b0, 3, 10);
    run_op("bp_next", 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 64'h00000001_00000000, 1'b0, 4, 0);

    // Reset while the high-word pass is in flight.
    @(negedge clk);
    in_a     = 64'hFFFFFFFF_FFFFFFFF;
    in_b     = 64'h00000000_00000001;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    check("mid_adder_a", {32'd0, adder_a}, 64'h00000000_FFFFFFFF);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_hi_busy", {63'd0, busy}, 64'd0);
    check("rst_hi_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_hi_out_sum", out_sum, 64'd0);
    run_op("post_rst", 64'h00000001_00000002, 64'h00000002_00000003, 64'h00000003_00000005, 1'b0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
